// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: operand width, ALU select
// encodings and the sequencer FSM state type.
package alu_seq_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOTA = 3'b100;
  localparam logic [2:0] OP_PASB = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_LT   = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// fourBitALU: 4-bit combinational ALU with zero, signed-overflow and carry flags.
// SUB computes A + ~B + XIN, so XIN=1 gives a plain two's-complement subtract.
module fourBitALU
  import alu_seq_pkg::*;
(
  input  logic             XIN,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [2:0]       S,
  output logic [ALU_W-1:0] F,
  output logic             Z,
  output logic             V,
  output logic             C
);

  logic [ALU_W-1:0] w_b_eff;
  logic [ALU_W:0]   w_sum;

  always_comb begin
    w_b_eff = (S == OP_SUB) ? ~B : B;
    w_sum   = {1'b0, A} + {1'b0, w_b_eff} + {{ALU_W{1'b0}}, XIN};
    F = '0;
    C = 1'b0;
    V = 1'b0;
    case (S)
      OP_ADD, OP_SUB: begin
        F = w_sum[ALU_W-1:0];
        C = w_sum[ALU_W];
        // Overflow: operands agree in sign but the result does not.
        V = (A[ALU_W-1] == w_b_eff[ALU_W-1]) && (w_sum[ALU_W-1] != A[ALU_W-1]);
      end
      OP_AND:  F = A & B;
      OP_OR:   F = A | B;
      OP_NOTA: F = ~A;
      OP_PASB: F = B;
      OP_XOR:  F = A ^ B;
      OP_LT:   F = {{(ALU_W-1){1'b0}}, ($signed(A) < $signed(B))};
      default: F = '0;
    endcase
    Z = (F == '0);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Clocked command front-end for fourBitALU: accepts a command, holds operands
// for SETTLE_CYCLES, captures the result, and hands it back over valid/ready.
// Optional statistics counters are built when ALU_SEQ_STATS_EN is defined.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [ALU_W-1:0] CMD_A,
  input  logic [ALU_W-1:0] CMD_B,
  input  logic             CMD_XIN,
  input  logic             CMD_ACC,
  input  logic             CMD_CHAIN,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [ALU_W-1:0] RSP_F,
  output logic             RSP_Z,
  output logic             RSP_V,
  output logic             RSP_C,
  output logic             BUSY
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] OP_CNT,
  output logic [CNT_W-1:0] OVF_CNT
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
    $error("alu_op_sequencer: SETTLE_CYCLES must be 1..15 and CNT_W >= 1");
  end

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_t       r_state;
  logic [3:0]       r_cnt;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [ALU_W-1:0] r_rsp_f;
  logic             r_rsp_z;
  logic             r_rsp_v;
  logic             r_rsp_c;
  logic [ALU_W-1:0] r_acc;
  logic             r_last_c;

  logic [ALU_W-1:0] r_a;
  logic [ALU_W-1:0] r_b;
  logic [2:0]       r_s;
  logic             r_xin;

  logic [ALU_W-1:0] w_f;
  logic             w_z;
  logic             w_v;
  logic             w_c;
  logic             w_capture;

  fourBitALU u_alu (
    .XIN (r_xin),
    .A   (r_a),
    .B   (r_b),
    .S   (r_s),
    .F   (w_f),
    .Z   (w_z),
    .V   (w_v),
    .C   (w_c)
  );

  assign w_capture = (r_state == SETTLE) && (r_cnt == 4'd0);

  // Ready is masked by RST so no command can be accepted on a reset edge.
  assign CMD_READY = r_cmd_ready & ~RST;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_F     = r_rsp_f;
  assign RSP_Z     = r_rsp_z;
  assign RSP_V     = r_rsp_v;
  assign RSP_C     = r_rsp_c;
  assign BUSY      = r_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_f     <= '0;
      r_rsp_z     <= 1'b0;
      r_rsp_v     <= 1'b0;
      r_rsp_c     <= 1'b0;
      r_acc       <= '0;
      r_last_c    <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= 3'd0;
      r_xin       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (CMD_VALID) begin
            r_a         <= CMD_ACC ? r_acc : CMD_A;
            r_xin       <= CMD_CHAIN ? r_last_c : CMD_XIN;
            r_b         <= CMD_B;
            r_s         <= CMD_OP;
            r_cnt       <= CNT_LOAD;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_capture) begin
            r_rsp_f     <= w_f;
            r_rsp_z     <= w_z;
            r_rsp_v     <= w_v;
            r_rsp_c     <= w_c;
            r_acc       <= w_f;
            r_last_c    <= w_c;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [CNT_W-1:0] r_op_cnt;
  logic [CNT_W-1:0] r_ovf_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op_cnt  <= '0;
      r_ovf_cnt <= '0;
    end else if (w_capture) begin
      r_op_cnt <= sat_inc(r_op_cnt);
      if (w_v) r_ovf_cnt <= sat_inc(r_ovf_cnt);
    end
  end

  assign OP_CNT  = r_op_cnt;
  assign OVF_CNT = r_ovf_cnt;
`endif

endmodule
